// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register front-end.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h70;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NAK          = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Register-file side of the I2C target: write strobes and read fetches.
interface i2c_target_regs_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_strobe;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rd_strobe,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rd_strobe,
    output rd_data
  );
endinterface

// File: rtl/i2c_filter.sv
// Two-flop synchroniser plus run-length glitch filter with edge pulses.
// Edge pulses are asserted in the same cycle the filtered level takes its new value.
module i2c_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, fall_q;

  // cnt_q counts consecutive synchronised samples that disagree with the level.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) level_d = sync_q[1];
      else                              cnt_d   = cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target turning bus transactions into register writes and read fetches,
// with sub-address auto-increment/wrap and repeated-start support.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = I2C_DEFAULT_ADDR,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3,
  parameter int         AUTO_INC   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      scl_in,
  input  logic                      sda_in,
  output logic                      sda_oe,
  output logic                      busy,
  i2c_target_regs_if.master         regs
);

  localparam int AW = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (scl_in),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (sda_in),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] sub_q, sub_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          rw_q, rw_d;
  logic          ack_phase_q, ack_phase_d;
  logic          rd_load_q, rd_load_d;
  logic          busy_q, busy_d;
  logic          sda_oe_q, sda_oe_d;
  logic          rd_strobe;
  logic          start_det, stop_det;
  logic [7:0]    rx_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  function automatic logic [AW-1:0] next_sub(input logic [AW-1:0] s);
    return (s == AW'(NUM_REGS - 1)) ? '0 : s + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sub_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      rd_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sub_q       <= sub_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rw_q        <= rw_d;
      ack_phase_q <= ack_phase_d;
      rd_load_q   <= rd_load_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  // ACK states see two SCL falls: the first drives the ACK, the second ends it.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sub_d       = sub_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rw_d        = rw_q;
    ack_phase_d = ack_phase_q;
    rd_load_d   = rd_load_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    rd_strobe   = 1'b0;

    if (start_det) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = '0;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      rd_load_d   = 1'b0;
    end else if (stop_det) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      rd_load_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == I2C_ADDR) begin
              busy_d      = 1'b1;
              rw_d        = rx_byte[0];
              ack_phase_d = 1'b0;
              state_d     = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_ADDR_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = ~I2C_ACK;
            ack_phase_d = 1'b1;
          end else begin
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            if (rw_q) begin
              rd_strobe = 1'b1;
              shift_d   = regs.rd_data;
              sda_oe_d  = ~regs.rd_data[7];
              state_d   = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_SUB;
            end
          end
        end

        ST_SUB: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
              sub_d       = rx_byte[AW-1:0];
              ack_phase_d = 1'b0;
              state_d     = ST_SUB_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_SUB_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = ~I2C_ACK;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            state_d     = ST_WDATA;
          end
        end

        ST_WDATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = sub_q;
            wr_data_d   = rx_byte;
            ack_phase_d = 1'b0;
            state_d     = ST_WDATA_ACK;
          end
        end

        ST_WDATA_ACK: if (scl_fall) begin
          if (!ack_phase_q) begin
            sda_oe_d    = ~I2C_ACK;
            ack_phase_d = 1'b1;
          end else begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b0;
            bit_cnt_d   = '0;
            if (AUTO_INC != 0) sub_d = next_sub(sub_q);
            state_d     = ST_WDATA;
          end
        end

        // Shift register rotates so the next bit to drive always sits in bit 6.
        ST_RDATA: begin
          if (scl_fall) begin
            if (rd_load_q) begin
              rd_strobe = 1'b1;
              shift_d   = regs.rd_data;
              sda_oe_d  = ~regs.rd_data[7];
              rd_load_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_phase_d = 1'b0;
              state_d     = ST_RDATA_ACK;
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_fall && !ack_phase_q) begin
            sda_oe_d    = 1'b0;
            ack_phase_d = 1'b1;
          end else if (scl_rise && ack_phase_q) begin
            ack_phase_d = 1'b0;
            if (sda_lvl == I2C_NAK) begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end else begin
              if (AUTO_INC != 0) sub_d = next_sub(sub_q);
              rd_load_d = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_RDATA;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe         = sda_oe_q;
  assign busy           = busy_q;
  assign regs.wr_en     = wr_en_q;
  assign regs.wr_addr   = wr_addr_q;
  assign regs.wr_data   = wr_data_q;
  assign regs.rd_addr   = sub_q;
  assign regs.rd_strobe = rd_strobe & ~rst;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, open-drain SDA model,
// scoreboard queues for register writes, read fetches and read-back bytes.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int NUM_REGS   = 16;
  localparam int AW         = 4;
  localparam int FILTER_LEN = 3;
  localparam int Q          = 20;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy;
  wire  sda_line = sda_m & ~sda_oe;

  i2c_target_regs_if #(.AW(AW)) regs ();
  assign regs.rd_data = 8'h40 + {4'h0, regs.rd_addr};

  i2c_target_regs #(
    .I2C_ADDR  (7'h70),
    .NUM_REGS  (NUM_REGS),
    .FILTER_LEN(FILTER_LEN),
    .AUTO_INC  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .scl_in(scl_m),
    .sda_in(sda_line),
    .sda_oe(sda_oe),
    .busy  (busy),
    .regs  (regs)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           wr_q[$];
  logic [AW-1:0] rs_q[$];
  logic [7:0]    rd_exp_q[$];
  logic          saw_start = 1'b0;

  always @(negedge clk) begin
    if (regs.wr_en) begin
      check("wr_rd_excl", regs.rd_strobe, 1'b0);
      if (wr_q.size() == 0) check("wr_unexpected", regs.wr_en, 1'b0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", regs.wr_addr, e.addr);
        check("wr_data", regs.wr_data, e.data);
      end
    end
    if (regs.rd_strobe) begin
      if (rs_q.size() == 0) check("rs_unexpected", regs.rd_strobe, 1'b0);
      else                  check("rs_addr", regs.rd_addr, rs_q.pop_front());
    end
    if (dut.state_q == ST_ADDR) saw_start = 1'b1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic v, output logic s);
    sda_m = v;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    s = sda_line;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    scl_m = 1'b0;
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~mack, s);
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_q.push_back('{addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    rs_q.push_back(a);
    rd_exp_q.push_back(8'h40 + {4'h0, a});
  endtask

  task automatic read_check(input string tag, input logic mack);
    logic [7:0] b;
    read_byte(mack, b);
    if (rd_exp_q.size() == 0) check({tag, "_noexp"}, b, 8'hxx);
    else                      check(tag, b, rd_exp_q.pop_front());
  endtask

  initial begin
    logic ack;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", regs.wr_en, 1'b0);
    check("rst_rd_strobe", regs.rd_strobe, 1'b0);
    check("rst_wr_addr", regs.wr_addr, '0);
    check("rst_wr_data", regs.wr_data, '0);
    check("rst_rd_addr", regs.rd_addr, '0);

    // Two-byte write with auto-increment.
    i2c_start();
    write_byte(8'hE0, ack); check("w_addr_ack", ack, 1'b1);
    check("w_busy", busy, 1'b1);
    write_byte(8'd10, ack); check("w_sub_ack", ack, 1'b1);
    exp_wr(4'd10, 8'h55);
    write_byte(8'h55, ack); check("w_d0_ack", ack, 1'b1);
    exp_wr(4'd11, 8'h1F);
    write_byte(8'h1F, ack); check("w_d1_ack", ack, 1'b1);
    i2c_stop();
    check("w_busy_stop", busy, 1'b0);

    // Foreign address: NAK and stay off the bus until the next START.
    i2c_start();
    write_byte(8'hE2, ack); check("nm_addr_nak", ack, 1'b0);
    check("nm_busy", busy, 1'b0);
    write_byte(8'h00, ack); check("nm_wait_nak", ack, 1'b0);
    i2c_stop();

    // Sub-address wrap and out-of-range sub-address.
    i2c_start();
    write_byte(8'hE0, ack); check("wrap_addr_ack", ack, 1'b1);
    write_byte(8'd15, ack); check("wrap_sub_ack", ack, 1'b1);
    exp_wr(4'd15, 8'hAA);
    write_byte(8'hAA, ack); check("wrap_d0_ack", ack, 1'b1);
    exp_wr(4'd0, 8'hBB);
    write_byte(8'hBB, ack); check("wrap_d1_ack", ack, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'hE0, ack); check("oor_addr_ack", ack, 1'b1);
    write_byte(8'd16, ack); check("oor_sub_nak", ack, 1'b0);
    write_byte(8'h77, ack); check("oor_data_nak", ack, 1'b0);
    i2c_stop();

    // Sub-address write, repeated START, two-byte read.
    i2c_start();
    write_byte(8'hE0, ack); check("rd_waddr_ack", ack, 1'b1);
    write_byte(8'd3, ack);  check("rd_sub_ack", ack, 1'b1);
    i2c_start();
    exp_rd(4'd3);
    exp_rd(4'd4);
    write_byte(8'hE1, ack); check("rd_raddr_ack", ack, 1'b1);
    read_check("rd_byte0", 1'b1);
    read_check("rd_byte1", 1'b0);
    i2c_stop();

    // Read with no sub-address phase continues from the retained pointer.
    i2c_start();
    exp_rd(4'd4);
    write_byte(8'hE1, ack); check("rd2_addr_ack", ack, 1'b1);
    read_check("rd2_byte0", 1'b0);
    i2c_stop();

    // SDA glitches while SCL is high in IDLE.
    saw_start = 1'b0;
    sda_m = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    sda_m = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_short_nostart", saw_start, 1'b0);
    check("glitch_short_idle", dut.state_q, ST_IDLE);
    sda_m = 1'b0;
    repeat (FILTER_LEN) @(negedge clk);
    sda_m = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_long_start", saw_start, 1'b1);
    check("glitch_long_idle", dut.state_q, ST_IDLE);

    // Reset in the 4th bit of a data byte, then a clean write.
    i2c_start();
    write_byte(8'hE0, ack); check("rs_addr_ack", ack, 1'b1);
    write_byte(8'd5, ack);  check("rs_sub_ack", ack, 1'b1);
    for (int i = 0; i < 3; i++) begin
      logic s;
      clock_bit(1'b1, s);
    end
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    check("rs_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rs_sda_oe", sda_oe, 1'b0);
    check("rs_busy_after", busy, 1'b0);
    rst = 1'b0;
    i2c_stop();
    i2c_start();
    write_byte(8'hE0, ack); check("post_addr_ack", ack, 1'b1);
    write_byte(8'd2, ack);  check("post_sub_ack", ack, 1'b1);
    exp_wr(4'd2, 8'h3C);
    write_byte(8'h3C, ack); check("post_data_ack", ack, 1'b1);
    i2c_stop();

    repeat (10) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 0);
    check("rs_q_drained", rs_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
